// File: rtl/fifo_ecc_pkg.sv
// Shared widths, scrubber state encoding and Hamming code helpers for the ECC FIFO.
// Code layout: codeword position p (1..CW) is bit p-1; powers of two hold check bits.
package fifo_ecc_pkg;

    localparam int DW  = 32;  // raw data width
    localparam int CW  = 38;  // encoded width
    localparam int PW  = 6;   // check bits / syndrome width
    localparam int SCW = 8;   // scrub write-back counter width

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CHECK = 2'd2,
        S_WB    = 2'd3
    } scrub_state_t;

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Data bit carried at codeword position p (p not a power of two).
    function automatic int data_index(input int p);
        return p - 1 - $clog2(p + 1);
    endfunction

    // Positions covered by check bit k: every position with bit k set.
    function automatic logic [CW-1:0] check_mask(input int k);
        logic [CW-1:0] m;
        m = '0;
        for (int p = 1; p <= CW; p++) begin
            if (((p >> k) & 1) != 0) begin
                m = m | (CW'(1) << (p - 1));
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/data_decode.sv
// Hamming decoder: a syndrome inside the codeword range is corrected (sec); one past it
// cannot name a bit and is reported as uncorrectable (ded).
module data_decode
    import fifo_ecc_pkg::*;
(
    input  logic [CW-1:0] code,
    output logic [DW-1:0] data,
    output logic          sec,
    output logic          ded
);

    logic [PW-1:0] syn;

    for (genvar gi = 0; gi < PW; gi++) begin : g_syn
        assign syn[gi] = ^(code & check_mask(gi));
    end

    for (genvar gi = 1; gi <= CW; gi++) begin : g_pos
        if (!is_pow2(gi)) begin : g_dat
            assign data[data_index(gi)] = code[gi-1] ^ (syn == PW'(gi));
        end
    end

    assign sec = (syn != '0) && (syn <= PW'(CW));
    assign ded = syn > PW'(CW);

endmodule

// File: rtl/data_encode.sv
// Hamming encoder: places data around the check positions and sets even check bits.
module data_encode
    import fifo_ecc_pkg::*;
(
    input  logic [DW-1:0] data,
    output logic [CW-1:0] code
);

    logic [CW-1:0] spread;
    logic [PW-1:0] syn;

    for (genvar gi = 1; gi <= CW; gi++) begin : g_pos
        if (is_pow2(gi)) begin : g_chk
            assign spread[gi-1] = 1'b0;
            assign code[gi-1]   = syn[$clog2(gi)];
        end else begin : g_dat
            assign spread[gi-1] = data[data_index(gi)];
            assign code[gi-1]   = data[data_index(gi)];
        end
    end

    for (genvar gi = 0; gi < PW; gi++) begin : g_syn
        assign syn[gi] = ^(spread & check_mask(gi));
    end

endmodule

// File: rtl/ecc_fifo_ctrl_scrub.sv
// Background scrubber (ecc_scrub_fsm), present only when ECC_SCRUB_EN is defined.
// Walks the FIFO entries on idle port cycles and writes back corrected words.
`ifdef ECC_SCRUB_EN
module ecc_scrub_fsm
    import fifo_ecc_pkg::*;
#(
    parameter int AW             = 4,
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [AW-1:0]  rd_ptr,
    input  logic [AW:0]    count,
    input  logic           dec_sec,
    input  logic           dec_ded,
    input  logic [DW-1:0]  dec_data,
    output logic           scrub_re,
    output logic           scrub_we,
    output logic [AW-1:0]  scrub_addr,
    output logic [DW-1:0]  scrub_data,
    output logic           ded_set,
    output logic [SCW-1:0] scrub_cnt
);

    localparam int IW = $clog2(SCRUB_INTERVAL + 1);

    scrub_state_t   state_reg, state_next;
    logic [AW-1:0]  ptr_reg, ptr_next;
    logic [IW-1:0]  ivl_reg, ivl_next;
    logic [DW-1:0]  wb_reg, wb_next;
    logic [SCW-1:0] cnt_reg, cnt_next;
    logic [AW-1:0]  dist;
    logic           occupied;

    // Entry is live when it lies within count slots ahead of the read pointer.
    assign dist     = ptr_reg - rd_ptr;
    assign occupied = {1'b0, dist} < count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            ptr_reg   <= '0;
            ivl_reg   <= '0;
            wb_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            ivl_reg   <= ivl_next;
            wb_reg    <= wb_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        ivl_next   = ivl_reg;
        wb_next    = wb_reg;
        cnt_next   = cnt_reg;
        scrub_re   = 1'b0;
        scrub_we   = 1'b0;
        ded_set    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (ivl_reg == IW'(SCRUB_INTERVAL - 1)) begin
                    ivl_next = '0;
                    if (occupied) state_next = S_READ;
                    else          ptr_next   = ptr_reg + 1'b1;
                end else begin
                    ivl_next = ivl_reg + 1'b1;
                end
            end
            S_READ: begin
                if (!pop) begin
                    scrub_re   = 1'b1;
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (dec_sec) begin
                    wb_next    = dec_data;
                    state_next = S_WB;
                end else begin
                    ded_set    = dec_ded;
                    ptr_next   = ptr_reg + 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_WB: begin
                // The write port is shared with pushes, which always win.
                if (!push) begin
                    if (occupied) begin
                        scrub_we = 1'b1;
                        if (cnt_reg != '1) cnt_next = cnt_reg + 1'b1;
                    end
                    ptr_next   = ptr_reg + 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign scrub_addr = ptr_reg;
    assign scrub_data = wb_reg;
    assign scrub_cnt  = cnt_reg;

endmodule
`endif

// File: rtl/ecc_fifo_ctrl.sv
// ECC FIFO sequencer: pointers, occupancy and RAM arbitration; optional scrubber under
// ECC_SCRUB_EN. rd_valid is registered; rd_data/err_* decode the RAM output in that cycle.
module ecc_fifo_ctrl
    import fifo_ecc_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int AW             = 4,
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [DW-1:0]  wr_data,
    input  logic           rd_en,
    output logic [DW-1:0]  rd_data,
    output logic           rd_valid,
    output logic           full,
    output logic           empty,
    output logic [AW:0]    count,
    output logic           overflow,
    output logic           underflow,
    output logic           err_sec,
    output logic           err_ded,
    output logic           ram_we,
    output logic [AW-1:0]  ram_waddr,
    output logic [CW-1:0]  ram_wdata,
    output logic           ram_re,
    output logic [AW-1:0]  ram_raddr,
    input  logic [CW-1:0]  ram_rdata,
    output logic [SCW-1:0] scrub_cnt,
    output logic           ded_sticky
);

    if ((1 << AW) != DEPTH || SCRUB_INTERVAL < 1) begin : g_cfg_check
        $error("ecc_fifo_ctrl: DEPTH must be 2**AW and SCRUB_INTERVAL >= 1");
    end

    logic [AW:0]   count_reg;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic          overflow_reg, underflow_reg, rd_valid_reg, ded_sticky_reg;
    logic          push, pop;
    logic [DW-1:0] enc_in, dec_data;
    logic [CW-1:0] enc_out;
    logic          dec_sec, dec_ded;
    logic          scrub_re, scrub_we, scrub_ded;
    logic [AW-1:0] scrub_addr;
    logic [DW-1:0] scrub_data;

    assign full  = count_reg == (AW+1)'(DEPTH);
    assign empty = count_reg == '0;
    assign count = count_reg;
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
            rd_valid_reg   <= 1'b0;
            ded_sticky_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
            overflow_reg   <= wr_en & full;
            underflow_reg  <= rd_en & empty;
            // rd_valid_reg doubles as the read tag: scrub reads leave it low.
            rd_valid_reg   <= pop;
            ded_sticky_reg <= ded_sticky_reg | (rd_valid_reg & dec_ded) | scrub_ded;
        end
    end

    // One encoder serves both pushes and scrub write-backs; they never share a cycle.
    assign enc_in = push ? wr_data : scrub_data;

    data_encode u_enc (.data(enc_in), .code(enc_out));
    data_decode u_dec (.code(ram_rdata), .data(dec_data), .sec(dec_sec), .ded(dec_ded));

    assign ram_we    = push | scrub_we;
    assign ram_waddr = push ? wr_ptr_reg : scrub_addr;
    assign ram_wdata = enc_out;
    assign ram_re    = pop | scrub_re;
    assign ram_raddr = pop ? rd_ptr_reg : scrub_addr;

    assign rd_valid   = rd_valid_reg;
    assign rd_data    = rd_valid_reg ? dec_data : '0;
    assign err_sec    = rd_valid_reg & dec_sec;
    assign err_ded    = rd_valid_reg & dec_ded;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;
    assign ded_sticky = ded_sticky_reg;

`ifdef ECC_SCRUB_EN
    ecc_scrub_fsm #(
        .AW             (AW),
        .SCRUB_INTERVAL (SCRUB_INTERVAL)
    ) u_scrub (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .rd_ptr     (rd_ptr_reg),
        .count      (count_reg),
        .dec_sec    (dec_sec),
        .dec_ded    (dec_ded),
        .dec_data   (dec_data),
        .scrub_re   (scrub_re),
        .scrub_we   (scrub_we),
        .scrub_addr (scrub_addr),
        .scrub_data (scrub_data),
        .ded_set    (scrub_ded),
        .scrub_cnt  (scrub_cnt)
    );
`else
    assign scrub_re   = 1'b0;
    assign scrub_we   = 1'b0;
    assign scrub_addr = '0;
    assign scrub_data = '0;
    assign scrub_ded  = 1'b0;
    assign scrub_cnt  = '0;
`endif

endmodule
